// File: rtl/zx_pkg.sv
// Shared Spectrum clocking definitions: machine model codes, CPU turbo codes and the
// page-contention lookup used by the CPU clock generator.
package zx_pkg;

  localparam logic [1:0] MODEL_48K  = 2'd0;
  localparam logic [1:0] MODEL_128K = 2'd1;
  localparam logic [1:0] MODEL_P3   = 2'd2;
  localparam logic [1:0] MODEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    TURBO_1X = 2'd0,
    TURBO_2X = 2'd1,
    TURBO_4X = 2'd2
  } turbo_t;

  // 4000-7FFF is contended on every ULA model; C000-FFFF only for the odd (128K) or
  // high (+3) RAM pages.
  function automatic logic contended(input logic [1:0] model, input logic [1:0] a15_14,
                                     input logic [2:0] ram_page);
    logic hit;
    logic unused_page_bit;
    hit = 1'b0;
    unused_page_bit = ram_page[1];
    if (model != MODEL_NONE && a15_14 == 2'b01) begin
      hit = 1'b1;
    end else if (a15_14 == 2'b11) begin
      if (model == MODEL_128K) hit = ram_page[0];
      else if (model == MODEL_P3) hit = ram_page[2];
    end
    return hit;
  endfunction

endpackage

// File: rtl/zx_ce_div.sv
// Master-clock divider: free-running phase counter and the fixed-phase pixel/PSG enables.
// Each enable is a registered decode of the current count, so it lags the count by one clock.
module zx_ce_div
  import zx_pkg::*;
#(
  parameter int DIV_LOG2 = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic [DIV_LOG2-1:0] ce,
  output logic                cep2x,
  output logic                cep1x,
  output logic                ne3M5,
  output logic                pe3M5
);

  localparam logic [DIV_LOG2-1:0] CE_LAST = '1;
  localparam logic [DIV_LOG2-1:0] CE_HALF = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce    <= '0;
      cep2x <= 1'b0;
      cep1x <= 1'b0;
      ne3M5 <= 1'b0;
      pe3M5 <= 1'b0;
    end else begin
      ce    <= ce + 1'b1;
      cep2x <= (ce[1:0] == 2'b11);
      cep1x <= (ce[2:0] == 3'b111);
      ne3M5 <= (ce == CE_HALF);
      pe3M5 <= (ce == CE_LAST);
    end
  end

endmodule

// File: rtl/zx_cpu_clkgen.sv
// CPU clock-enable generator: fixed-phase enables from zx_ce_div plus turbo selection and
// ULA memory/IO contention that withholds whole ne/pe CPU periods.
module zx_cpu_clkgen
  import zx_pkg::*;
#(
  parameter int DIV_LOG2 = 4,
  parameter bit TURBO_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  model,
  input  logic [1:0]  turbo,
  input  logic        vduC,
  input  logic        mreq,
  input  logic        iorq,
  input  logic [15:0] a,
  input  logic [2:0]  ramPage,
  output logic        cep2x,
  output logic        cep1x,
  output logic        ne3M5,
  output logic        pe3M5,
  output logic        necpu,
  output logic        pecpu,
  output logic        stalled
);

  localparam logic [DIV_LOG2-1:0] CE_LAST = '1;
  localparam logic [DIV_LOG2-1:0] CE_HALF = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);

  logic [DIV_LOG2-1:0] ce;
  turbo_t              turbo_req;
  turbo_t              turbo_act;
  logic                ne_slot;
  logic                pe_slot;
  logic                ula_io;
  logic                io_contend;
  logic                withhold;
  logic                bypass;
  logic                t1;
  logic                hold;
  logic                unused_addr;

  zx_ce_div #(.DIV_LOG2(DIV_LOG2)) u_div (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .cep2x (cep2x),
    .cep1x (cep1x),
    .ne3M5 (ne3M5),
    .pe3M5 (pe3M5)
  );

  assign unused_addr = ^a[13:1];

  always_comb begin
    turbo_req = TURBO_1X;
    if (TURBO_EN && turbo != 2'd3) turbo_req = turbo_t'(turbo);
  end

  // Every mode places a pe on the last count, so switching there can never double-pulse.
  always_comb begin
    ne_slot = 1'b0;
    pe_slot = 1'b0;
    case (turbo_act)
      TURBO_4X: begin
        ne_slot = (ce[1:0] == 2'd1);
        pe_slot = (ce[1:0] == 2'd3);
      end
      TURBO_2X: begin
        ne_slot = (ce[2:0] == 3'd3);
        pe_slot = (ce[2:0] == 3'd7);
      end
      default: begin
        ne_slot = (ce == CE_HALF);
        pe_slot = (ce == CE_LAST);
      end
    endcase
  end

  assign ula_io     = !iorq && !a[0];
  assign io_contend = ula_io && (model == MODEL_48K || model == MODEL_128K);
  assign withhold   = vduC && t1 && (contended(model, a[15:14], ramPage) || io_contend);
  assign bypass     = (turbo_act != TURBO_1X) || (model == MODEL_NONE);

  // The withhold decision is taken at the ne slot and held for the matching pe slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      turbo_act <= TURBO_1X;
      t1        <= 1'b0;
      hold      <= 1'b0;
      necpu     <= 1'b0;
      pecpu     <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      necpu <= 1'b0;
      pecpu <= 1'b0;
      if (ce == CE_LAST) turbo_act <= turbo_req;
      if (bypass) begin
        necpu   <= ne_slot;
        pecpu   <= pe_slot;
        hold    <= 1'b0;
        stalled <= 1'b0;
        if (pe_slot) t1 <= mreq && !ula_io;
      end else begin
        if (ne_slot) begin
          hold  <= withhold;
          necpu <= !withhold;
          if (withhold) stalled <= 1'b1;
        end
        if (pe_slot && !hold) begin
          pecpu   <= 1'b1;
          stalled <= 1'b0;
          t1      <= mreq && !ula_io;
        end
      end
    end
  end

endmodule

// File: tb/tb_zx_cpu_clkgen.sv
// Directed bench for zx_cpu_clkgen: free-run phases, turbo switching, contention table, reset.
module tb_zx_cpu_clkgen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  model = 2'd3;
  logic [1:0]  turbo = 2'd0;
  logic        vduC = 1'b0;
  logic        mreq = 1'b1;
  logic        iorq = 1'b1;
  logic [15:0] a = 16'h8000;
  logic [2:0]  ramPage = 3'd0;
  logic        cep2x, cep1x, ne3M5, pe3M5, necpu, pecpu, stalled;

  int checks = 0;
  int fails = 0;
  int n = 0;

  typedef struct {
    logic [1:0]  model;
    logic [1:0]  turbo;
    logic [15:0] addr;
    logic [2:0]  page;
    bit          io;
    bit          stall;
  } vec_t;

  vec_t vecs[14];

  zx_cpu_clkgen dut (
    .clock   (clock),
    .reset   (reset),
    .model   (model),
    .turbo   (turbo),
    .vduC    (vduC),
    .mreq    (mreq),
    .iorq    (iorq),
    .a       (a),
    .ramPage (ramPage),
    .cep2x   (cep2x),
    .cep1x   (cep1x),
    .ne3M5   (ne3M5),
    .pe3M5   (pe3M5),
    .necpu   (necpu),
    .pecpu   (pecpu),
    .stalled (stalled)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    n++;
  endtask

  // {cep2x, cep1x, ne3M5, pe3M5, necpu, pecpu, stalled} after edge k counted from reset release
  function automatic logic [6:0] expect_outs(input int k, input bit fast);
    logic ne_c, pe_c;
    ne_c = fast ? (k % 4 == 2) : (k % 16 == 8);
    pe_c = fast ? (k % 4 == 0) : (k % 16 == 0);
    return {k % 4 == 0, k % 8 == 0, k % 16 == 8, k % 16 == 0, ne_c, pe_c, 1'b0};
  endfunction

  // which: 0 = pecpu, 1 = pe3M5, 2 = stalled
  task automatic wait_for(input int which, input int budget, output bit found, output int cnt);
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < budget) begin
      step();
      cnt++;
      case (which)
        0: found = pecpu;
        1: found = pe3M5;
        default: found = stalled;
      endcase
    end
  endtask

  initial begin
    bit found, saw_pe, saw_st;
    int cnt;

    //           model  turbo  addr      page  io    stall
    vecs[0]  = '{2'd0, 2'd0, 16'h4000, 3'd0, 1'b0, 1'b1};
    vecs[1]  = '{2'd0, 2'd0, 16'h8000, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{2'd0, 2'd0, 16'hC000, 3'd1, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, 2'd0, 16'hC000, 3'd3, 1'b0, 1'b1};
    vecs[4]  = '{2'd1, 2'd0, 16'hC000, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{2'd2, 2'd0, 16'hC000, 3'd4, 1'b0, 1'b1};
    vecs[6]  = '{2'd2, 2'd0, 16'hC000, 3'd1, 1'b0, 1'b0};
    vecs[7]  = '{2'd3, 2'd0, 16'h4000, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{2'd1, 2'd0, 16'h00FE, 3'd0, 1'b1, 1'b1};
    vecs[9]  = '{2'd2, 2'd0, 16'h00FE, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{2'd0, 2'd0, 16'h00FE, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{2'd1, 2'd1, 16'h4000, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{2'd1, 2'd1, 16'h00FE, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{2'd2, 2'd0, 16'h00FF, 3'd0, 1'b1, 1'b0};

    repeat (3) @(negedge clock);
    check("reset_outputs", {cep2x, cep1x, ne3M5, pe3M5, necpu, pecpu, stalled}, 7'd0);
    reset = 1'b1;
    n = 0;

    // Free run, no contention, 1x
    repeat (64) begin
      step();
      check("free_run", {cep2x, cep1x, ne3M5, pe3M5, necpu, pecpu, stalled}, expect_outs(n, 1'b0));
    end

    // Request 14 MHz at ce=5; takes effect after the pe3M5 at edge 80
    while (n < 69) step();
    turbo = 2'd2;
    while (n < 112) begin
      step();
      check("turbo_up", {cep2x, cep1x, ne3M5, pe3M5, necpu, pecpu, stalled}, expect_outs(n, n > 80));
    end
    while (n < 118) step();
    turbo = 2'd0;
    while (n < 160) begin
      step();
      check("turbo_down", {cep2x, cep1x, ne3M5, pe3M5, necpu, pecpu, stalled}, expect_outs(n, n <= 128));
    end

    // Contention table
    for (int i = 0; i < 14; i++) begin
      model = vecs[i].model;
      turbo = vecs[i].turbo;
      ramPage = vecs[i].page;
      vduC = 1'b0;
      mreq = 1'b1;
      iorq = 1'b1;
      a = 16'h8000;
      repeat (20) step();
      wait_for(0, 40, found, cnt);
      check($sformatf("vec%0d_setup_pe", i), found, 1'b1);
      a = vecs[i].addr;
      if (vecs[i].io) iorq = 1'b0;
      else mreq = 1'b0;
      vduC = 1'b1;
      saw_pe = 1'b0;
      saw_st = 1'b0;
      repeat (32) begin
        step();
        if (pecpu) saw_pe = 1'b1;
        if (stalled) saw_st = 1'b1;
      end
      check($sformatf("vec%0d_pecpu_seen", i), saw_pe, !vecs[i].stall);
      check($sformatf("vec%0d_stalled_seen", i), saw_st, vecs[i].stall);
      if (vecs[i].stall) begin
        wait_for(1, 20, found, cnt);
        check($sformatf("vec%0d_pe3M5_in_stall", i), found, 1'b1);
        vduC = 1'b0;
        wait_for(0, 20, found, cnt);
        check($sformatf("vec%0d_recover_clocks", i), cnt, 16);
        check($sformatf("vec%0d_stalled_cleared", i), stalled, 1'b0);
      end
    end

    // Asynchronous reset in the middle of a stall
    model = 2'd0;
    turbo = 2'd0;
    vduC = 1'b0;
    mreq = 1'b1;
    iorq = 1'b1;
    a = 16'h8000;
    repeat (20) step();
    wait_for(0, 40, found, cnt);
    check("rst_setup_pe", found, 1'b1);
    a = 16'h4000;
    mreq = 1'b0;
    vduC = 1'b1;
    wait_for(2, 32, found, cnt);
    check("rst_stall_entered", found, 1'b1);
    #2 reset = 1'b0;
    #1 check("rst_mid_stall_outputs", {cep2x, cep1x, ne3M5, pe3M5, necpu, pecpu, stalled}, 7'd0);
    @(negedge clock);
    vduC = 1'b0;
    mreq = 1'b1;
    reset = 1'b1;
    n = 0;
    wait_for(1, 40, found, cnt);
    check("rst_first_pe3M5_clock", cnt, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
